instruction_prefetch: RTL

Parametrised next-generation fetch stage that decouples instruction memory from decode. It issues sequential fetch requests ahead of demand and buffers returned words in a DEPTH-entry prefetch queue. On a branch redirect it flushes the queue and discards stale responses. It sits between the instruction-memory port and the decode stage, replacing the single-entry fetch register.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/instruction_prefetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage defaults, queue-level width helper and the default queue entry layout.
// Pure declarations; no logic, no latency.
package fetch_pkg;

  localparam int unsigned DEF_PC_STEP  = 4;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_IWIDTH   = 32;
  localparam int unsigned DEF_PC_WIDTH = 32;

  typedef struct packed {
    logic [DEF_IWIDTH-1:0]   instr;
    logic [DEF_PC_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; push/pop take effect at the next edge, head is a register mux.
// No internal backpressure: the caller never pushes when full unless it also pops.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              push_dat_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              head_dat_o,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch stage: one outstanding sequential request, DEPTH-entry prefetch queue, redirect flush.
// Zero-wait memory gives 1 instr/cycle; requests stop while queue plus in-flight slot is full.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned IWIDTH   = 32,
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                          f_clk,
  input  logic                          f_rst,
  output logic                          f_o_syn,
  output logic [AWIDTH-1:0]             f_o_addr_instr,
  input  logic                          f_i_ack,
  input  logic [IWIDTH-1:0]             f_i_instr,
  input  logic                          f_change_pc,
  input  logic [PC_WIDTH-1:0]           f_alu_pc_value,
  input  logic                          f_i_stall,
  output logic                          f_o_ce,
  output logic [IWIDTH-1:0]             f_o_instr,
  output logic [PC_WIDTH-1:0]           f_pc,
  output logic                          f_o_stall,
  output logic [level_width(DEPTH)-1:0] f_o_level
);

  localparam int unsigned         LW         = level_width(DEPTH);
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(PC_STEP - 1);
  localparam logic [LW-1:0]       DEPTH_LVL  = LW'(DEPTH);

  typedef struct packed {
    logic [IWIDTH-1:0]   instr;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  logic                syn_q, syn_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                discard_q, discard_d;

  logic                acked;
  logic                push;
  logic                pop;
  logic                bus_free;
  logic                issue;
  logic [PC_WIDTH-1:0] base_pc;
  logic [LW-1:0]       lvl_next;
  logic                q_empty;
  logic                q_full;
  entry_t              push_entry;
  entry_t              head_entry;

  // pc_q is the PC of the next request to issue; req_pc_q tags the one on the bus.
  always_comb begin
    acked    = syn_q & f_i_ack;
    push     = acked & ~discard_q & ~f_change_pc;
    pop      = f_o_ce & ~f_i_stall;
    base_pc  = f_change_pc ? (f_alu_pc_value & ALIGN_MASK) : pc_q;
    bus_free = ~syn_q | f_i_ack;

    lvl_next = f_o_level;
    if (f_change_pc) begin
      lvl_next = '0;
    end else if (push && !pop) begin
      lvl_next = f_o_level + LW'(1);
    end else if (pop && !push) begin
      lvl_next = f_o_level - LW'(1);
    end

    // The next request's slot is reserved as soon as it issues.
    issue = bus_free & (lvl_next < DEPTH_LVL);

    syn_d     = syn_q;
    addr_d    = addr_q;
    req_pc_d  = req_pc_q;
    pc_d      = base_pc;
    discard_d = discard_q;

    if (acked) begin
      discard_d = 1'b0;
    end else if (syn_q && f_change_pc) begin
      discard_d = 1'b1;
    end

    if (bus_free) begin
      syn_d = issue;
      if (issue) begin
        addr_d   = base_pc[AWIDTH-1:0];
        req_pc_d = base_pc;
        pc_d     = base_pc + STEP;
      end
    end
  end

  always_ff @(posedge f_clk) begin
    if (!f_rst) begin
      syn_q     <= 1'b0;
      addr_q    <= '0;
      req_pc_q  <= '0;
      pc_q      <= PC_WIDTH'(RESET_PC);
      discard_q <= 1'b0;
    end else begin
      syn_q     <= syn_d;
      addr_q    <= addr_d;
      req_pc_q  <= req_pc_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  assign push_entry = '{instr: f_i_instr, pc: req_pc_q};

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (f_clk),
    .rst_n      (f_rst),
    .flush_i    (f_change_pc),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .head_dat_o (head_entry),
    .level_o    (f_o_level),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  assign f_o_syn        = syn_q;
  assign f_o_addr_instr = addr_q;
  assign f_o_ce         = ~q_empty & ~f_change_pc;
  assign f_o_instr      = head_entry.instr;
  assign f_pc           = head_entry.pc;
  assign f_o_stall      = q_full;

endmodule
